decode_stage_hz: RTL and testbench

- Next-generation MIPS-subset decode stage: owns the F/D pipeline register, the register-file read addresses, and an N-way forwarding network.
- Resolves branches and jumps in D; stalls on pending hazards and on a busy multiply/divide unit.
- Sits between fetch and execute, with valid/ready handshakes on both sides and a flush input from later stages.

---
 rtl/decode_stage_hz.sv | 184 ++++++++++++++++++
 tb/tb_decode_stage_hz.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_hz.sv
// Decode stage: F/D register, forwarding network, hazard stall and branch/jump resolution.
// Zero-cycle decode of the held instruction; holds while stalled or E is not ready.
module decode_stage_hz #(
  parameter int XLEN       = 32,
  parameter int NUM_FWD    = 3,
  parameter int DELAY_SLOT = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    f_valid_i,
  input  logic [31:0]             f_instr_i,
  input  logic [XLEN-1:0]         f_pc_i,
  output logic                    f_ready_o,
  input  logic                    flush_i,
  output logic [4:0]              rf_addr1_o,
  output logic [4:0]              rf_addr2_o,
  input  logic [XLEN-1:0]         rf_data1_i,
  input  logic [XLEN-1:0]         rf_data2_i,
  input  logic [NUM_FWD-1:0]      fwd_valid_i,
  input  logic [NUM_FWD-1:0]      fwd_pending_i,
  input  logic [5*NUM_FWD-1:0]    fwd_addr_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data_i,
  input  logic                    mdu_busy_i,
  input  logic                    e_ready_i,
  output logic                    d_valid_o,
  output logic [31:0]             d_instr_o,
  output logic [XLEN-1:0]         d_pc_o,
  output logic [XLEN-1:0]         d_rs_o,
  output logic [XLEN-1:0]         d_rt_o,
  output logic [XLEN-1:0]         d_imm_o,
  output logic                    d_mdu_use_o,
  output logic                    redirect_valid_o,
  output logic [XLEN-1:0]         redirect_pc_o
);

  logic            full_q, full_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt;
  logic [15:0] imm16;
  logic [25:0] imm26;

  assign op    = instr_q[31:26];
  assign rs    = instr_q[25:21];
  assign rt    = instr_q[20:16];
  assign imm16 = instr_q[15:0];
  assign imm26 = instr_q[25:0];
  assign funct = instr_q[5:0];

  logic is_rtype, is_jr, is_shift_imm, is_mf, is_mdu, rs_used, rt_used;

  assign is_rtype     = (op == 6'h00);
  assign is_jr        = is_rtype && (funct inside {6'h08, 6'h09});
  assign is_shift_imm = is_rtype && (funct inside {6'h00, 6'h02, 6'h03});
  assign is_mf        = is_rtype && (funct inside {6'h10, 6'h12});
  assign is_mdu       = is_rtype && (funct inside {6'h10, 6'h11, 6'h12, 6'h13,
                                                   6'h18, 6'h19, 6'h1A, 6'h1B});
  assign rs_used = !(op inside {6'h02, 6'h03, 6'h0F}) && !is_shift_imm && !is_mf;
  assign rt_used = (is_rtype && !is_jr && !(funct inside {6'h10, 6'h11, 6'h12, 6'h13}))
                || (op inside {6'h04, 6'h05, 6'h28, 6'h29, 6'h2B});

  logic [XLEN-1:0] rs_val, rt_val;
  logic            rs_pend, rt_pend;

  // Scan oldest to youngest so the lowest matching index wins.
  always_comb begin
    rs_val  = rf_data1_i;
    rt_val  = rf_data2_i;
    rs_pend = 1'b0;
    rt_pend = 1'b0;
    for (int i = NUM_FWD-1; i >= 0; i--) begin
      if (fwd_valid_i[i] && (fwd_addr_i[5*i +: 5] == rs)) begin
        rs_val  = fwd_data_i[XLEN*i +: XLEN];
        rs_pend = fwd_pending_i[i];
      end
      if (fwd_valid_i[i] && (fwd_addr_i[5*i +: 5] == rt)) begin
        rt_val  = fwd_data_i[XLEN*i +: XLEN];
        rt_pend = fwd_pending_i[i];
      end
    end
    if (rs == 5'd0) begin
      rs_val  = '0;
      rs_pend = 1'b0;
    end
    if (rt == 5'd0) begin
      rt_val  = '0;
      rt_pend = 1'b0;
    end
  end

  logic stall, d_valid, issue, accept, f_ready, taken, redirect;
  logic [XLEN-1:0] pc4, br_tgt, j_tgt, tgt;

  assign stall   = full_q && ((rs_used && rs_pend) || (rt_used && rt_pend) || (is_mdu && mdu_busy_i));
  assign d_valid = full_q && !stall && !flush_i;
  assign issue   = d_valid && e_ready_i;
  assign f_ready = !full_q || issue;
  assign accept  = f_valid_i && f_ready && !flush_i;

  assign pc4    = pc_q + XLEN'(4);
  assign br_tgt = pc4 + {{(XLEN-18){imm16[15]}}, imm16, 2'b00};
  assign j_tgt  = {pc4[XLEN-1:28], imm26, 2'b00};

  always_comb begin
    taken = 1'b0;
    tgt   = br_tgt;
    case (op)
      6'h00: if (is_jr) begin
        taken = 1'b1;
        tgt   = rs_val;
      end
      6'h01: begin
        if (rt == 5'd0)      taken = rs_val[XLEN-1];
        else if (rt == 5'd1) taken = !rs_val[XLEN-1];
      end
      6'h02, 6'h03: begin
        taken = 1'b1;
        tgt   = j_tgt;
      end
      6'h04: taken = (rs_val == rt_val);
      6'h05: taken = (rs_val != rt_val);
      6'h06: taken = rs_val[XLEN-1] || (rs_val == '0);
      6'h07: taken = !rs_val[XLEN-1] && (rs_val != '0);
      default: taken = 1'b0;
    endcase
  end

  assign redirect = issue && taken;

  always_comb begin
    case (op)
      6'h0C, 6'h0D, 6'h0E: d_imm_o = {{(XLEN-16){1'b0}}, imm16};
      6'h0F:               d_imm_o = {{(XLEN-32){1'b0}}, imm16, 16'h0000};
      default:             d_imm_o = {{(XLEN-16){imm16[15]}}, imm16};
    endcase
  end

  // Without a delay slot, the word fetched alongside a redirect is the wrong-path one.
  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      full_d = 1'b0;
    end else if (accept) begin
      if ((DELAY_SLOT == 0) && redirect) begin
        full_d = 1'b0;
      end else begin
        full_d  = 1'b1;
        instr_d = f_instr_i;
        pc_d    = f_pc_i;
      end
    end else if (issue) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign f_ready_o        = f_ready;
  assign rf_addr1_o       = rs;
  assign rf_addr2_o       = rt;
  assign d_valid_o        = d_valid;
  assign d_instr_o        = instr_q;
  assign d_pc_o           = pc_q;
  assign d_rs_o           = rs_val;
  assign d_rt_o           = rt_val;
  assign d_mdu_use_o      = is_mdu;
  assign redirect_valid_o = redirect;
  assign redirect_pc_o    = redirect ? tgt : '0;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Bench for decode_stage_hz: two instances (delay slot on / off) checked every cycle against a reference model.
module tb_decode_stage_hz;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_valid, flush, mdu_busy, e_ready;
  logic [31:0] f_instr, f_pc, rf_data1, rf_data2;
  logic [2:0]  fwd_valid, fwd_pending;
  logic [14:0] fwd_addr;
  logic [95:0] fwd_data;

  logic        dv[2], fr[2], rv[2], mdu[2];
  logic [4:0]  a1[2], a2[2];
  logic [31:0] o_instr[2], o_pc[2], o_rs[2], o_rt[2], o_imm[2], o_rpc[2];

  int total = 0;
  int bad   = 0;
  bit run   = 1'b0;

  always #5 clk = ~clk;

  decode_stage_hz #(.XLEN(32), .NUM_FWD(3), .DELAY_SLOT(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .f_valid_i(f_valid), .f_instr_i(f_instr), .f_pc_i(f_pc),
    .f_ready_o(fr[0]), .flush_i(flush), .rf_addr1_o(a1[0]), .rf_addr2_o(a2[0]),
    .rf_data1_i(rf_data1), .rf_data2_i(rf_data2), .fwd_valid_i(fwd_valid),
    .fwd_pending_i(fwd_pending), .fwd_addr_i(fwd_addr), .fwd_data_i(fwd_data),
    .mdu_busy_i(mdu_busy), .e_ready_i(e_ready), .d_valid_o(dv[0]), .d_instr_o(o_instr[0]),
    .d_pc_o(o_pc[0]), .d_rs_o(o_rs[0]), .d_rt_o(o_rt[0]), .d_imm_o(o_imm[0]),
    .d_mdu_use_o(mdu[0]), .redirect_valid_o(rv[0]), .redirect_pc_o(o_rpc[0]));

  decode_stage_hz #(.XLEN(32), .NUM_FWD(3), .DELAY_SLOT(0)) dut_nds (
    .clk_i(clk), .rst_ni(rst_n), .f_valid_i(f_valid), .f_instr_i(f_instr), .f_pc_i(f_pc),
    .f_ready_o(fr[1]), .flush_i(flush), .rf_addr1_o(a1[1]), .rf_addr2_o(a2[1]),
    .rf_data1_i(rf_data1), .rf_data2_i(rf_data2), .fwd_valid_i(fwd_valid),
    .fwd_pending_i(fwd_pending), .fwd_addr_i(fwd_addr), .fwd_data_i(fwd_data),
    .mdu_busy_i(mdu_busy), .e_ready_i(e_ready), .d_valid_o(dv[1]), .d_instr_o(o_instr[1]),
    .d_pc_o(o_pc[1]), .d_rs_o(o_rs[1]), .d_rt_o(o_rt[1]), .d_imm_o(o_imm[1]),
    .d_mdu_use_o(mdu[1]), .redirect_valid_o(rv[1]), .redirect_pc_o(o_rpc[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: architectural view of one held instruction per instance.
  logic        m_full[2];
  logic [31:0] m_instr[2], m_pc[2];

  typedef struct packed {
    logic        dv, fr, rv, mdu;
    logic [31:0] rs, rt, imm, rpc;
  } exp_t;

  function automatic logic [31:0] m_opnd(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return 32'd0;
    for (int i = 0; i < 3; i++)
      if (fwd_valid[i] && fwd_addr[i*5 +: 5] == r) return fwd_data[i*32 +: 32];
    return rf;
  endfunction

  function automatic logic m_pend(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    for (int i = 0; i < 3; i++)
      if (fwd_valid[i] && fwd_addr[i*5 +: 5] == r) return fwd_pending[i];
    return 1'b0;
  endfunction

  function automatic void m_class(input logic [31:0] ins, output logic ur, output logic ut,
                                  output logic md);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    ur = 1'b1; ut = 1'b0; md = 1'b0;
    if (op == 6'h00) begin
      case (fn)
        6'h00, 6'h02, 6'h03: begin ur = 1'b0; ut = 1'b1; end
        6'h08, 6'h09:        ut = 1'b0;
        6'h10, 6'h12:        begin ur = 1'b0; md = 1'b1; end
        6'h11, 6'h13:        md = 1'b1;
        6'h18, 6'h19, 6'h1A, 6'h1B: begin ut = 1'b1; md = 1'b1; end
        default:             ut = 1'b1;
      endcase
    end else begin
      case (op)
        6'h02, 6'h03, 6'h0F:               ur = 1'b0;
        6'h04, 6'h05, 6'h28, 6'h29, 6'h2B: ut = 1'b1;
        default: ;
      endcase
    end
  endfunction

  function automatic exp_t m_eval(input int k);
    exp_t e;
    logic ur, ut, md, stall, tk;
    logic [31:0] ins, pc, tgt;
    int sa, off;
    ins = m_instr[k];
    pc  = m_pc[k];
    m_class(ins, ur, ut, md);
    e.rs  = m_opnd(ins[25:21], rf_data1);
    e.rt  = m_opnd(ins[20:16], rf_data2);
    e.mdu = md;
    case (ins[31:26])
      6'h0C, 6'h0D, 6'h0E: e.imm = {16'h0, ins[15:0]};
      6'h0F:               e.imm = {ins[15:0], 16'h0};
      default:             e.imm = 32'($signed(ins[15:0]));
    endcase
    sa  = $signed(e.rs);
    off = $signed(ins[15:0]);
    tgt = pc + 32'd4 + 32'(off * 4);
    tk  = 1'b0;
    case (ins[31:26])
      6'h00: if (ins[5:0] == 6'h08 || ins[5:0] == 6'h09) begin tk = 1'b1; tgt = e.rs; end
      6'h01: tk = (ins[20:16] == 5'd0) ? (sa < 0) : (ins[20:16] == 5'd1) ? (sa >= 0) : 1'b0;
      6'h02, 6'h03: begin tk = 1'b1; tgt = ((pc + 32'd4) & 32'hF000_0000) | (ins[25:0] * 4); end
      6'h04: tk = (e.rs == e.rt);
      6'h05: tk = (e.rs != e.rt);
      6'h06: tk = (sa <= 0);
      6'h07: tk = (sa > 0);
      default: tk = 1'b0;
    endcase
    stall = (ur && m_pend(ins[25:21])) || (ut && m_pend(ins[20:16])) || (md && mdu_busy);
    e.dv  = m_full[k] && !stall && !flush;
    e.fr  = !m_full[k] || (e.dv && e_ready);
    e.rv  = e.dv && e_ready && tk;
    e.rpc = e.rv ? tgt : 32'd0;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      e = m_eval(k);
      if (!rst_n) begin
        m_full[k] <= 1'b0; m_instr[k] <= 32'd0; m_pc[k] <= 32'd0;
      end else if (flush) begin
        m_full[k] <= 1'b0;
      end else if (f_valid && e.fr) begin
        if (k == 1 && e.rv) m_full[k] <= 1'b0;
        else begin
          m_full[k] <= 1'b1; m_instr[k] <= f_instr; m_pc[k] <= f_pc;
        end
      end else if (e.dv && e_ready) begin
        m_full[k] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (run && rst_n) begin
      for (int k = 0; k < 2; k++) begin
        exp_t e;
        e = m_eval(k);
        chk($sformatf("m%0d.d_valid", k), 32'(dv[k]), 32'(e.dv));
        chk($sformatf("m%0d.f_ready", k), 32'(fr[k]), 32'(e.fr));
        chk($sformatf("m%0d.redir_v", k), 32'(rv[k]), 32'(e.rv));
        chk($sformatf("m%0d.redir_pc", k), o_rpc[k], e.rpc);
        chk($sformatf("m%0d.mdu_use", k), 32'(mdu[k]), 32'(e.mdu));
        chk($sformatf("m%0d.d_rs", k), o_rs[k], e.rs);
        chk($sformatf("m%0d.d_rt", k), o_rt[k], e.rt);
        chk($sformatf("m%0d.d_imm", k), o_imm[k], e.imm);
        chk($sformatf("m%0d.d_instr", k), o_instr[k], m_instr[k]);
        chk($sformatf("m%0d.d_pc", k), o_pc[k], m_pc[k]);
        chk($sformatf("m%0d.rf_addr", k), {22'd0, a1[k], a2[k]}, {22'd0, m_instr[k][25:16]});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int i, input logic [4:0] a, input logic [31:0] d);
    fwd_addr[i*5 +: 5]  = a;
    fwd_data[i*32 +: 32] = d;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
    f_valid = 1'b1; f_instr = ins; f_pc = pc;
  endtask

  logic [31:0] imm_ins[3];
  logic [31:0] imm_exp[3];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; f_valid = 1'b0; f_instr = 32'd0; f_pc = 32'd0; flush = 1'b0;
    mdu_busy = 1'b0; e_ready = 1'b0; rf_data1 = 32'd0; rf_data2 = 32'd0;
    fwd_valid = 3'b000; fwd_pending = 3'b000; fwd_addr = 15'd0; fwd_data = 96'd0;
    imm_ins = '{32'h2408_8001, 32'h3C08_1234, 32'h3408_8001};
    imm_exp = '{32'hFFFF_8001, 32'h1234_0000, 32'h0000_8001};

    // Reset state
    tick; tick;
    @(negedge clk);
    chk("rst.d_valid", 32'(dv[0]), 32'd0);
    chk("rst.f_ready", 32'(fr[0]), 32'd1);
    chk("rst.redir_v", 32'(rv[0]), 32'd0);
    chk("rst.d_instr", o_instr[0], 32'd0);
    chk("rst.redir_pc", o_rpc[0], 32'd0);
    tick;
    rst_n = 1'b1; run = 1'b1;

    // Forwarding priority on a held addu $3,$1,$2
    fwd_valid = 3'b011; set_fwd(0, 5'd1, 32'h11); set_fwd(1, 5'd1, 32'h22);
    rf_data1 = 32'h55; rf_data2 = 32'h66;
    offer(32'h0022_1821, 32'h100);
    tick; f_valid = 1'b0;
    @(negedge clk);
    chk("fwd.prio0", o_rs[0], 32'h11);
    chk("fwd.valid", 32'(dv[0]), 32'd1);
    chk("fwd.rt_rf", o_rt[0], 32'h66);
    tick; fwd_valid = 3'b010;
    @(negedge clk); chk("fwd.prio1", o_rs[0], 32'h22);
    tick; fwd_valid = 3'b000;
    @(negedge clk); chk("fwd.rf", o_rs[0], 32'h55);
    tick; e_ready = 1'b1;
    @(negedge clk); chk("fwd.issue", 32'(dv[0]), 32'd1);
    tick;
    @(negedge clk); chk("fwd.empty", 32'(dv[0]), 32'd0);

    // Back-to-back immediates
    for (int i = 0; i < 3; i++) begin
      offer(imm_ins[i], 32'h200 + 32'(4 * i));
      tick;
      @(negedge clk);
      chk($sformatf("imm.%0d", i), o_imm[0], imm_exp[i]);
      chk($sformatf("imm.dv%0d", i), 32'(dv[0]), 32'd1);
    end
    f_valid = 1'b0;
    tick;

    // Load-use stall on beq $4,$5,0x10 then taken
    fwd_valid = 3'b010; fwd_pending = 3'b010; set_fwd(1, 5'd4, 32'h7); rf_data2 = 32'h7;
    offer(32'h1085_0010, 32'h3000);
    tick; f_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("lu.dv%0d", c), 32'(dv[0]), 32'd0);
      chk($sformatf("lu.fr%0d", c), 32'(fr[0]), 32'd0);
      tick;
    end
    fwd_pending = 3'b000;
    @(negedge clk);
    chk("lu.redir_v", 32'(rv[0]), 32'd1);
    chk("lu.redir_pc", o_rpc[0], 32'h3044);
    tick;
    @(negedge clk); chk("lu.pulse", 32'(rv[0]), 32'd0);

    // mflo against a busy MDU
    fwd_valid = 3'b000; mdu_busy = 1'b1;
    offer(32'h0000_1012, 32'h400);
    tick; f_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("mdu.dv%0d", c), 32'(dv[0]), 32'd0);
      chk($sformatf("mdu.use%0d", c), 32'(mdu[0]), 32'd1);
      tick;
    end
    mdu_busy = 1'b0;
    @(negedge clk);
    chk("mdu.dv6", 32'(dv[0]), 32'd1);
    chk("mdu.use6", 32'(mdu[0]), 32'd1);
    tick;

    // jal and jr
    offer(32'h0C40_0000, 32'h3000);
    tick; f_valid = 1'b0;
    @(negedge clk);
    chk("jal.v", 32'(rv[0]), 32'd1);
    chk("jal.pc", o_rpc[0], 32'h0100_0000);
    tick;
    rf_data1 = 32'h3008; rf_data2 = 32'hDEAD;
    offer(32'h03E0_0008, 32'h4000);
    tick; f_valid = 1'b0;
    @(negedge clk); chk("jr.pc", o_rpc[0], 32'h3008);
    tick;

    // Delay slot behaviour: j with the next word offered in the same cycle
    offer(32'h0800_0040, 32'h1000);
    tick;
    offer(32'h0022_1821, 32'h1004);
    @(negedge clk);
    chk("ds.redir_pc", o_rpc[1], 32'h100);
    tick; f_valid = 1'b0;
    @(negedge clk);
    chk("ds1.dv", 32'(dv[0]), 32'd1);
    chk("ds1.pc", o_pc[0], 32'h1004);
    chk("ds0.dv", 32'(dv[1]), 32'd0);
    tick;

    // Flush during a stalled bne $6,$7
    fwd_valid = 3'b001; fwd_pending = 3'b001; set_fwd(0, 5'd6, 32'h11);
    offer(32'h14C7_0008, 32'h5000);
    tick; f_valid = 1'b0;
    @(negedge clk); chk("fl.stall", 32'(dv[0]), 32'd0);
    tick;
    flush = 1'b1; fwd_pending = 3'b000;
    offer(32'h2408_8001, 32'h5004);
    @(negedge clk);
    chk("fl.noredir", 32'(rv[0]), 32'd0);
    chk("fl.dv", 32'(dv[0]), 32'd0);
    tick; flush = 1'b0; f_valid = 1'b0;
    @(negedge clk);
    chk("fl.empty_dv", 32'(dv[0]), 32'd0);
    chk("fl.empty_fr", 32'(fr[0]), 32'd1);

    // Asynchronous reset while holding
    e_ready = 1'b0;
    offer(32'h0022_1821, 32'h600);
    tick; f_valid = 1'b0;
    @(negedge clk); chk("ar.held", 32'(dv[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.dv", 32'(dv[0]), 32'd0);
    chk("ar.fr", 32'(fr[0]), 32'd1);
    tick; rst_n = 1'b1; e_ready = 1'b1;
    @(negedge clk);
    chk("ar.after_dv", 32'(dv[0]), 32'd0);
    chk("ar.after_rv", 32'(rv[0]), 32'd0);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
